recom: RTL

- Inverse of the lazy-wavelet split stage. Takes even/odd sample pairs from the synthesis (inverse lifting) path and re-interleaves them into one serial sample stream at twice the pair rate: even[n], odd[n], even[n+1], ...
- Sits at the output of the inverse wavelet datapath. A small pair FIFO absorbs back-pressure from the downstream consumer.

---
 rtl/recom.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/recom.sv
// ---------------------------------------------------------------------------
// recom -- lazy-wavelet recombination (inverse of the even/odd split).
//
// Accepts {even, odd, last} sample pairs from the inverse lifting datapath,
// buffers them in a small pair FIFO, and re-emits them as a single serial
// stream at twice the pair rate: even[n], odd[n], even[n+1], odd[n+1], ...
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   in_even      in   even-phase sample (index 2n)
//   in_odd       in   odd-phase sample (index 2n+1)
//   in_last      in   pair is the last pair of a line
//   in_valid     in   pair present
//   in_ready     out  a pair can be accepted this cycle
//   out_data     out  serial reconstructed sample
//   out_last     out  out_data is the final sample of a line
//   out_valid    out  out_data valid
//   out_ready    in   consumer accepts out_data this cycle
//   overflow_err out  sticky: in_valid seen while in_ready was low
// ---------------------------------------------------------------------------
module recom #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int AW     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_even,
    input  logic [DATA_W-1:0] in_odd,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow_err
);

    typedef enum logic {
        PH_EVEN = 1'b0,
        PH_ODD  = 1'b1
    } phase_t;

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [DATA_W-1:0] r_mem_even [DEPTH];
    logic [DATA_W-1:0] r_mem_odd  [DEPTH];
    logic              r_mem_last [DEPTH];

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    phase_t        r_phase;
    phase_t        w_phase_next;
    logic          r_overflow;

    logic w_full;
    logic w_empty;
    logic w_out_valid;
    logic w_push;
    logic w_fire;
    logic w_pop;

    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);

    // in_ready looks only at the stored count, never at the same-cycle pop,
    // so no combinational path runs from out_ready to in_ready.
    assign in_ready    = !rst && !w_full;
    assign w_out_valid = !rst && !w_empty;
    assign out_valid   = w_out_valid;

    assign w_push = in_valid && in_ready;
    assign w_fire = w_out_valid && out_ready;
    // A pair leaves the FIFO only once its odd sample has been taken.
    assign w_pop  = w_fire && (r_phase == PH_ODD);

    // Phase register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= PH_EVEN;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    // Phase next-state and output selection
    always_comb begin
        w_phase_next = r_phase;
        out_data     = '0;
        out_last     = 1'b0;

        if (w_fire) begin
            case (r_phase)
                PH_EVEN: w_phase_next = PH_ODD;
                PH_ODD:  w_phase_next = PH_EVEN;
                default: w_phase_next = PH_EVEN;
            endcase
        end

        if (w_out_valid) begin
            if (r_phase == PH_EVEN) begin
                out_data = r_mem_even[r_rptr];
            end else begin
                out_data = r_mem_odd[r_rptr];
                out_last = r_mem_last[r_rptr];
            end
        end
    end

    // Pair storage; writes never touch the head slot while the FIFO is
    // non-full, so the presented sample stays stable under back-pressure.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_even[r_wptr] <= in_even;
            r_mem_odd[r_wptr]  <= in_odd;
            r_mem_last[r_wptr] <= in_last;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow flag; the offered pair is dropped, never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (in_valid && !in_ready) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow_err = r_overflow;

endmodule
